// File: rtl/mux_pkg.sv
// Shared definitions for the mux / arbiter family: index-width helper,
// arbitration mode encodings and the per-cycle handshake action type.
package mux_pkg;

    // Arbitration mode values for the RR parameter.
    localparam bit ARB_FIXED = 1'b0;
    localparam bit ARB_RR    = 1'b1;

    // Value an output register's valid flag takes out of reset.
    localparam logic VALID_RST = 1'b0;

    // What the output register does on a given cycle.
    typedef enum logic [1:0] {
        XFER_IDLE,   // empty and nothing eligible
        XFER_LOAD,   // accept a new word (covers drain-and-refill)
        XFER_DRAIN,  // consumer takes the word, nothing to refill with
        XFER_STALL   // word held, consumer not ready
    } xfer_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int calc_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks one requester, either the first one at or
// above ptr (wrapping back to 0) or simply the lowest index.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  bit RR = ARB_RR,
    localparam int CW = calc_cw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [CW-1:0] gnt_idx,
    output logic          any_gnt
);

    // Search origin; fixed priority always starts at channel 0.
    logic [CW-1:0] start;
    assign start = (RR == ARB_RR) ? ptr : '0;

    // Two passes: first the requesters at or above start, then wrap to the
    // lowest requester. An out-of-range start simply falls to the second pass.
    always_comb begin
        // NOTE: every output gets a default before any conditional assignment,
        // otherwise the unassigned paths would infer latches.
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_gnt    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_gnt && req[i] && (CW'(i) >= start)) begin
                any_gnt       = 1'b1;
                gnt_idx       = CW'(i);
                gnt_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any_gnt && req[i]) begin
                any_gnt       = 1'b1;
                gnt_idx       = CW'(i);
                gnt_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_rr.sv
// N-channel registered multiplexer with valid/ready on every side. An
// internal arbiter picks the source; force_en restricts eligibility to a
// single channel. One output register stage absorbs backpressure.
module mux_arb_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    parameter  bit RR    = ARB_RR,
    localparam int CW    = calc_cw(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               force_en,
    input  logic [CW-1:0]      force_sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [CW-1:0]      out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [N-1:0]     elig;
    logic [N-1:0]     gnt_onehot;
    logic [CW-1:0]    gnt_idx;
    logic             any_gnt;
    logic             acc;
    logic [WIDTH-1:0] sel_data;
    xfer_e            xfer;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    ptr_q, ptr_d;

    // Eligible set: requests, narrowed to force_sel when forcing. A force_sel
    // beyond the last channel matches nothing, so nothing is eligible.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = in_valid[i] && (!force_en || (force_sel == CW'(i)));
        end
    end

    rr_arbiter #(
        .N  (N),
        .RR (RR)
    ) u_arb (
        .req        (elig),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any_gnt    (any_gnt)
    );

    // AND-OR select of the granted channel's word.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_onehot[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Classify the cycle; the register can take a word whenever it is empty
    // or being emptied this cycle, so drain and refill happen together.
    always_comb begin
        acc  = !out_valid_q || out_ready;
        xfer = XFER_IDLE;
        if (!acc) begin
            xfer = XFER_STALL;
        end else if (any_gnt) begin
            xfer = XFER_LOAD;
        end else if (out_valid_q) begin
            xfer = XFER_DRAIN;
        end
    end

    assign in_ready = (xfer == XFER_LOAD) ? gnt_onehot : '0;

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        case (xfer)
            XFER_LOAD: begin
                out_data_d  = sel_data;
                out_ch_d    = gnt_idx;
                out_valid_d = 1'b1;
                if (RR == ARB_RR) begin
                    ptr_d = (gnt_idx == CW'(N - 1)) ? '0 : gnt_idx + CW'(1);
                end
            end
            XFER_DRAIN: begin
                out_valid_d = 1'b0;
            end
            default: begin
                // idle and stall hold everything
            end
        endcase
    end

    // Output and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data and channel registers are reset too, not just
            // valid, because their post-reset value of zero is visible on the
            // outputs and relied upon downstream.
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= VALID_RST;
            ptr_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_rr.sv
// Bench for mux_arb_rr: three instances (N=4 round-robin, N=4 fixed
// priority, N=3 round-robin) share one stimulus stream and are compared every
// cycle against a queue-free behavioural model, plus directed scenarios.
module tb_mux_arb_rr;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_data;
    logic [3:0]  s_valid;
    logic        s_fen;
    logic [1:0]  s_fsel;
    logic        s_ordy;

    logic [3:0]  ir [3];
    logic [2:0]  ir_n3;
    logic [7:0]  od [3];
    logic [1:0]  och [3];
    logic        ov [3];

    assign ir[2] = {1'b0, ir_n3};

    mux_arb_rr #(.WIDTH(8), .N(4), .RR(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_data(s_data), .in_valid(s_valid),
        .in_ready(ir[0]), .force_en(s_fen), .force_sel(s_fsel),
        .out_data(od[0]), .out_ch(och[0]), .out_valid(ov[0]), .out_ready(s_ordy)
    );

    mux_arb_rr #(.WIDTH(8), .N(4), .RR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_data(s_data), .in_valid(s_valid),
        .in_ready(ir[1]), .force_en(s_fen), .force_sel(s_fsel),
        .out_data(od[1]), .out_ch(och[1]), .out_valid(ov[1]), .out_ready(s_ordy)
    );

    mux_arb_rr #(.WIDTH(8), .N(3), .RR(1'b1)) dut_n3 (
        .clk(clk), .rst_n(rst_n), .in_data(s_data[23:0]), .in_valid(s_valid[2:0]),
        .in_ready(ir_n3), .force_en(s_fen), .force_sel(s_fsel),
        .out_data(od[2]), .out_ch(och[2]), .out_valid(ov[2]), .out_ready(s_ordy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int   m_n  [3] = '{4, 4, 3};
    bit   m_rr [3] = '{1'b1, 1'b0, 1'b1};
    bit   m_valid [3];
    int   m_data  [3];
    int   m_ch    [3];
    int   m_ptr   [3];

    int n_vec;
    int n_miss;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Channel granted to instance j this cycle, or -1.
    function automatic int model_grant(input int j);
        int n;
        int c;
        n = m_n[j];
        for (int k = 0; k < n; k++) begin
            c = m_rr[j] ? (m_ptr[j] + k) % n : k;
            if (s_valid[c] && (!s_fen || int'(s_fsel) == c)) return c;
        end
        return -1;
    endfunction

    function automatic bit model_acc(input int j);
        return !m_valid[j] || s_ordy;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            m_valid[j] = 1'b0;
            m_data[j]  = 0;
            m_ch[j]    = 0;
            m_ptr[j]   = 0;
        end
    endtask

    task automatic check_all();
        int g;
        int exp_ir;
        for (int j = 0; j < 3; j++) begin
            g      = model_grant(j);
            exp_ir = (model_acc(j) && g >= 0) ? (1 << g) : 0;
            chk($sformatf("in_ready[%0d]", j), 32'(ir[j]), 32'(exp_ir));
            chk($sformatf("out_valid[%0d]", j), 32'(ov[j]), 32'(m_valid[j]));
            chk($sformatf("out_data[%0d]", j), 32'(od[j]), 32'(m_data[j]));
            chk($sformatf("out_ch[%0d]", j), 32'(och[j]), 32'(m_ch[j]));
        end
    endtask

    task automatic model_update();
        int g;
        for (int j = 0; j < 3; j++) begin
            g = model_grant(j);
            if (model_acc(j) && g >= 0) begin
                m_data[j]  = int'(s_data[g*8 +: 8]);
                m_ch[j]    = g;
                m_valid[j] = 1'b1;
                if (m_rr[j]) m_ptr[j] = (g + 1) % m_n[j];
            end else if (m_valid[j] && s_ordy) begin
                m_valid[j] = 1'b0;
            end
        end
    endtask

    // Inputs were driven at the falling edge; check, advance the model, then
    // return at the next falling edge.
    task automatic cycle();
        #1;
        check_all();
        if (!rst_n) model_reset();
        else        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec   = 0;
        n_miss  = 0;
        s_data  = 32'hA3A2A1A0;
        s_valid = 4'b0000;
        s_fen   = 1'b0;
        s_fsel  = 2'd0;
        s_ordy  = 1'b1;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state, then release with nothing requesting.
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("rst_in_ready", 32'(ir[0]), 32'h0);

        // Round-robin fairness on all four channels.
        s_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_seq_ch", 32'(och[0]), 32'(k % 4));
            chk("rr_seq_data", 32'(od[0]), 32'(8'hA0 + k % 4));
        end

        // Fixed priority: channel 1 always beats channel 3.
        s_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("fp_ch", 32'(och[1]), 32'd1);
            chk("fp_in_ready", 32'(ir[1]), 32'h2);
        end

        // Backpressure for three cycles, then resume with no bubble.
        s_valid = 4'b1111;
        s_data  = 32'hB3B2B1B0;
        s_ordy  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_in_ready", 32'(ir[0]), 32'h0);
            chk("bp_valid", 32'(ov[0]), 32'd1);
        end
        s_ordy = 1'b1;
        cycle();
        chk("bp_resume_valid", 32'(ov[0]), 32'd1);
        chk("bp_resume_data", 32'(od[0][7:4]), 32'hB);

        // Forced select of channel 2.
        s_fen  = 1'b1;
        s_fsel = 2'd2;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("force_ch", 32'(och[0]), 32'd2);
            chk("force_in_ready", 32'(ir[0]), 32'h4);
        end
        s_valid = 4'b1011;
        cycle();
        chk("force_drain_valid", 32'(ov[0]), 32'd0);
        chk("force_drain_n3", 32'(ov[2]), 32'd0);

        // Stream, then reset mid-stream: outputs clear without a clock edge.
        s_fen   = 1'b0;
        s_valid = 4'b0101;
        s_data  = 32'hC3C2C1C0;
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("arst_valid[%0d]", j), 32'(ov[j]), 32'd0);
            chk($sformatf("arst_data[%0d]", j), 32'(od[j]), 32'd0);
            chk($sformatf("arst_ch[%0d]", j), 32'(och[j]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        cycle();
        rst_n = 1'b1;

        // N=3 wrap with channels 0 and 2 requesting.
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("n3_wrap_ch", 32'(och[2]), (k % 2 == 0) ? 32'd0 : 32'd2);
        end

        // Randomized traffic, including forcing toggled under stall.
        for (int k = 0; k < 600; k++) begin
            s_data  = $urandom;
            s_valid = 4'($urandom);
            s_fen   = ($urandom_range(0, 3) == 0);
            s_fsel  = 2'($urandom);
            s_ordy  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
